eeprom_arb: RTL and testbench

EEPROM_ARB -- requirements
Module: eeprom_arb

---
 rtl/eeprom_pkg.sv | 28 ++
 rtl/eeprom_rr_pick.sv | 31 +++
 rtl/eeprom_arb.sv | 247 ++++++++++++++++++++++++
 tb/tb_eeprom_arb.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eeprom_pkg
// Purpose  : Shared widths, FSM state encoding and a counter-width helper for
//            the two-port EEPROM arbiter.
// Contents : ADDR_W, DATA_W, state_t, cnt_width()
// Revision : 1.0 - initial release
// ============================================================================
package eeprom_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT    = 3'd1,
    ISSUE    = 3'd2,
    WAIT_ACK = 3'd3,
    RECOVER  = 3'd4
  } state_t;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eeprom_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : eeprom_rr_pick
// Purpose  : Two-way round-robin selection. A sole requester wins; when both
//            request, the port that was not granted last wins.
// Ports    : req[1:0] in  - request vector (bit n = port n)
//            last     in  - port granted most recently
//            winner   out - selected port (meaningful when valid)
//            valid    out - at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module eeprom_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/eeprom_arb.sv
`default_nettype none
// ============================================================================
// Module   : eeprom_arb
// Purpose  : Arbitrates two request ports onto a single EEPROM serial master.
//            One transaction outstanding at a time; writes are followed by an
//            enforced idle gap; a missing EE_ACK is aborted after a timeout.
// Ports    : CLK, RESET               - clock, synchronous active-high reset
//            REQn/WEn/ADDRn/WDATAn     - per-port request and its fields
//            GNTn/DONEn/ERRn/RDATAn    - per-port accept, completion, timeout,
//                                        last read byte
//            BUSY                      - arbiter not idle
//            EE_WR/EE_RD/EE_ADDR       - start pulses and address to master
//            EE_DATA (inout)           - write byte out / read byte in
//            EE_ACK                    - end-of-transaction from master
// Revision : 1.0 - initial release
// ============================================================================
module eeprom_arb
  import eeprom_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int WR_GAP_CYC  = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              DONE0,
  output logic              DONE1,
  output logic              ERR0,
  output logic              ERR1,
  output logic [DATA_W-1:0] RDATA0,
  output logic [DATA_W-1:0] RDATA1,
  output logic              BUSY,
  output logic              EE_WR,
  output logic              EE_RD,
  output logic [ADDR_W-1:0] EE_ADDR,
  inout  wire  [DATA_W-1:0] EE_DATA,
  input  logic              EE_ACK
);

  localparam int c_tmo_w = cnt_width(TIMEOUT_CYC);
  localparam int c_gap_w = cnt_width(WR_GAP_CYC);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(WR_GAP_CYC - 1);

  // State and latched request
  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last;
  logic                r_port;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_tmo_w-1:0]  r_tmo_cnt;
  logic [c_gap_w-1:0]  r_gap_cnt;

  // Registered outputs
  logic [1:0]          r_gnt;
  logic [1:0]          r_done;
  logic [1:0]          r_err;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                r_busy;
  logic                r_ee_wr;
  logic                r_ee_rd;
  logic [ADDR_W-1:0]   r_ee_addr;
  logic                r_ee_oe;

  // Next-state values
  logic                w_last_nxt;
  logic                w_port_nxt;
  logic                w_we_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   w_wdata_nxt;
  logic [c_tmo_w-1:0]  w_tmo_nxt;
  logic [c_gap_w-1:0]  w_gap_nxt;
  logic [1:0]          w_gnt_nxt;
  logic [1:0]          w_done_nxt;
  logic [1:0]          w_err_nxt;
  logic [DATA_W-1:0]   w_rdata0_nxt;
  logic [DATA_W-1:0]   w_rdata1_nxt;
  logic                w_ee_wr_nxt;
  logic                w_ee_rd_nxt;
  logic [ADDR_W-1:0]   w_ee_addr_nxt;
  logic                w_ee_oe_nxt;

  logic                w_pick_winner;
  logic                w_pick_valid;

  eeprom_rr_pick u_rr_pick (
    .req    ({REQ1, REQ0}),
    .last   (r_last),
    .winner (w_pick_winner),
    .valid  (w_pick_valid)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_port_nxt    = r_port;
    w_we_nxt      = r_we;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_tmo_nxt     = r_tmo_cnt;
    w_gap_nxt     = r_gap_cnt;
    w_gnt_nxt     = 2'b00;
    w_done_nxt    = 2'b00;
    w_err_nxt     = 2'b00;
    w_rdata0_nxt  = r_rdata0;
    w_rdata1_nxt  = r_rdata1;
    w_ee_wr_nxt   = 1'b0;
    w_ee_rd_nxt   = 1'b0;
    w_ee_addr_nxt = r_ee_addr;
    w_ee_oe_nxt   = r_ee_oe;

    case (r_state)
      IDLE: begin
        // Fields are captured on the same edge that raises GNT, so the
        // requester may change them as soon as it sees the grant.
        if (w_pick_valid) begin
          w_state_nxt              = GRANT;
          w_gnt_nxt[w_pick_winner] = 1'b1;
          w_last_nxt               = w_pick_winner;
          w_port_nxt               = w_pick_winner;
          w_we_nxt                 = w_pick_winner ? WE1    : WE0;
          w_addr_nxt               = w_pick_winner ? ADDR1  : ADDR0;
          w_wdata_nxt              = w_pick_winner ? WDATA1 : WDATA0;
        end
      end

      GRANT: begin
        w_state_nxt   = ISSUE;
        w_ee_wr_nxt   = r_we;
        w_ee_rd_nxt   = ~r_we;
        w_ee_addr_nxt = r_addr;
        w_ee_oe_nxt   = r_we;
      end

      ISSUE: begin
        w_state_nxt = WAIT_ACK;
        w_tmo_nxt   = '0;
      end

      WAIT_ACK: begin
        // An acknowledge on the final timeout cycle still counts as success.
        if (EE_ACK) begin
          w_done_nxt[r_port] = 1'b1;
          w_ee_oe_nxt        = 1'b0;
          if (r_we) begin
            w_state_nxt = RECOVER;
            w_gap_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
            if (r_port)
              w_rdata1_nxt = EE_DATA;
            else
              w_rdata0_nxt = EE_DATA;
          end
        end else if (r_tmo_cnt == c_tmo_last) begin
          w_done_nxt[r_port] = 1'b1;
          w_err_nxt[r_port]  = 1'b1;
          w_ee_oe_nxt        = 1'b0;
          w_state_nxt        = RECOVER;
          w_gap_nxt          = '0;
        end else begin
          w_tmo_nxt = r_tmo_cnt + 1'b1;
        end
      end

      RECOVER: begin
        if (r_gap_cnt == c_gap_last)
          w_state_nxt = IDLE;
        else
          w_gap_nxt = r_gap_cnt + 1'b1;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      // Marking port 1 as last granted makes port 0 win the first contest.
      r_last    <= 1'b1;
      r_port    <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tmo_cnt <= '0;
      r_gap_cnt <= '0;
      r_gnt     <= 2'b00;
      r_done    <= 2'b00;
      r_err     <= 2'b00;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_busy    <= 1'b0;
      r_ee_wr   <= 1'b0;
      r_ee_rd   <= 1'b0;
      r_ee_addr <= '0;
      r_ee_oe   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_port    <= w_port_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_tmo_cnt <= w_tmo_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_gnt     <= w_gnt_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_rdata0  <= w_rdata0_nxt;
      r_rdata1  <= w_rdata1_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_ee_wr   <= w_ee_wr_nxt;
      r_ee_rd   <= w_ee_rd_nxt;
      r_ee_addr <= w_ee_addr_nxt;
      r_ee_oe   <= w_ee_oe_nxt;
    end
  end

  assign GNT0    = r_gnt[0];
  assign GNT1    = r_gnt[1];
  assign DONE0   = r_done[0];
  assign DONE1   = r_done[1];
  assign ERR0    = r_err[0];
  assign ERR1    = r_err[1];
  assign RDATA0  = r_rdata0;
  assign RDATA1  = r_rdata1;
  assign BUSY    = r_busy;
  assign EE_WR   = r_ee_wr;
  assign EE_RD   = r_ee_rd;
  assign EE_ADDR = r_ee_addr;
  assign EE_DATA = r_ee_oe ? r_wdata : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_eeprom_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_eeprom_arb
// Purpose  : Self-checking bench for eeprom_arb: directed scenarios followed
//            by randomized transactions, checked against a transaction-level
//            reference model (round-robin winner, completion latency, error
//            flag, per-port read byte).
// Revision : 1.0 - initial release
// ============================================================================
module tb_eeprom_arb;
  import eeprom_pkg::*;

  localparam int T = 32;  // TIMEOUT_CYC
  localparam int G = 5;   // WR_GAP_CYC

  logic              CLK = 1'b0;
  logic              RESET;
  logic              REQ0, REQ1, WE0, WE1;
  logic [ADDR_W-1:0] ADDR0, ADDR1;
  logic [DATA_W-1:0] WDATA0, WDATA1;
  logic              GNT0, GNT1, DONE0, DONE1, ERR0, ERR1;
  logic [DATA_W-1:0] RDATA0, RDATA1;
  logic              BUSY, EE_WR, EE_RD;
  logic [ADDR_W-1:0] EE_ADDR;
  wire  [DATA_W-1:0] EE_DATA;
  logic              EE_ACK;

  // EEPROM master model drives the data bus only while returning a read byte.
  logic              tb_oe;
  logic [DATA_W-1:0] tb_dat;
  assign EE_DATA = tb_oe ? tb_dat : {DATA_W{1'bz}};

  // Reference model state
  int                m_last;
  logic [DATA_W-1:0] m_rdata [2];

  int n_checks;
  int n_errors;

  int   won, prev_won;
  logic got;

  eeprom_arb #(.TIMEOUT_CYC(T), .WR_GAP_CYC(G)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .ERR0(ERR0), .ERR1(ERR1), .RDATA0(RDATA0), .RDATA1(RDATA1),
    .BUSY(BUSY), .EE_WR(EE_WR), .EE_RD(EE_RD), .EE_ADDR(EE_ADDR),
    .EE_DATA(EE_DATA), .EE_ACK(EE_ACK)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},   {30'd0, GNT1, GNT0}, 0);
    chk({tag, "_done"},  {30'd0, DONE1, DONE0}, 0);
    chk({tag, "_err"},   {30'd0, ERR1, ERR0}, 0);
    chk({tag, "_busy"},  {31'd0, BUSY}, 0);
    chk({tag, "_eewr"},  {31'd0, EE_WR}, 0);
    chk({tag, "_eerd"},  {31'd0, EE_RD}, 0);
    chk({tag, "_rd0"},   {24'd0, RDATA0}, 0);
    chk({tag, "_rd1"},   {24'd0, RDATA1}, 0);
    chk({tag, "_eeadr"}, {21'd0, EE_ADDR}, 0);
  endtask

  // One complete transaction. delay = cycles after the EE_WR/EE_RD pulse at
  // which the master acknowledges; values outside 1..T mean the ack is never
  // seen in WAIT_ACK (0 pulses it during the issue cycle, >T never pulses).
  // keep=1 leaves the requests high throughout; keep=0 drops them on grant.
  task automatic txn(input logic [1:0] mask, input bit keep, input int delay,
                     input logic [DATA_W-1:0] rdval, output int win);
    bit                we, ack_ok, seen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    int                exp_done;

    win  = (mask == 2'b11) ? 1 - m_last : (mask[1] ? 1 : 0);
    REQ0 = mask[0];
    REQ1 = mask[1];
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (GNT0 || GNT1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("grant_seen", {31'd0, seen}, 1);
    if (!seen) begin
      REQ0 = 1'b0;
      REQ1 = 1'b0;
      return;
    end
    chk("grant_port", {30'd0, GNT1, GNT0}, 32'd1 << win);
    we   = (win != 0) ? WE1 : WE0;
    addr = (win != 0) ? ADDR1 : ADDR0;
    wd   = (win != 0) ? WDATA1 : WDATA0;
    m_last = win;
    if (!keep) begin
      // Requests withdrawn and fields scrambled: the latched copy must be used.
      REQ0 = 1'b0;
      REQ1 = 1'b0;
      WE0 = 1'($urandom); WE1 = 1'($urandom);
      ADDR0 = ADDR_W'($urandom); ADDR1 = ADDR_W'($urandom);
      WDATA0 = DATA_W'($urandom); WDATA1 = DATA_W'($urandom);
    end

    ack_ok   = (delay >= 1) && (delay <= T);
    exp_done = ack_ok ? delay + 1 : T + 1;
    step();
    for (int cyc = 0; cyc <= exp_done; cyc++) begin
      EE_ACK = 1'b0;
      tb_oe  = 1'b0;
      if (cyc == exp_done) break;
      if (cyc == 0) begin
        chk("issue_wr",  {31'd0, EE_WR}, {31'd0, we});
        chk("issue_rd",  {31'd0, EE_RD}, {31'd0, !we});
        chk("issue_gnt", {30'd0, GNT1, GNT0}, 0);
      end else begin
        chk("wait_pulses", {28'd0, EE_WR, EE_RD, GNT1, GNT0}, 0);
        chk("wait_done",   {28'd0, DONE1, DONE0, ERR1, ERR0}, 0);
        chk("wait_busy",   {31'd0, BUSY}, 1);
      end
      chk("ee_addr", {21'd0, EE_ADDR}, {21'd0, addr});
      if (we) chk("ee_data_wr", {24'd0, EE_DATA}, {24'd0, wd});
      else    chk("ee_data_rel", {31'd0, (EE_DATA !== wd)}, 1);
      if (cyc == delay) begin
        EE_ACK = 1'b1;
        if (!we) begin
          tb_oe  = 1'b1;
          tb_dat = rdval;
        end
      end
      step();
    end

    if (ack_ok && !we) m_rdata[win] = rdval;
    chk("done_port", {30'd0, DONE1, DONE0}, 32'd1 << win);
    chk("err_flag",  {30'd0, ERR1, ERR0}, ack_ok ? 0 : (32'd1 << win));
    chk("rdata0",    {24'd0, RDATA0}, {24'd0, m_rdata[0]});
    chk("rdata1",    {24'd0, RDATA1}, {24'd0, m_rdata[1]});

    if (ack_ok && !we) begin
      chk("rd_idle_busy", {31'd0, BUSY}, 0);
    end else begin
      if (we) chk("ee_data_after_wr", {31'd0, (EE_DATA !== wd)}, 1);
      for (int j = 0; j < G; j++) begin
        chk("rec_busy", {31'd0, BUSY}, 1);
        chk("rec_gnt",  {30'd0, GNT1, GNT0}, 0);
        if (j > 0) chk("rec_done", {28'd0, DONE1, DONE0, ERR1, ERR0}, 0);
        if (!keep) begin
          if (win != 0) REQ0 = 1'b1; else REQ1 = 1'b1;
        end
        EE_ACK = 1'($urandom);
        step();
      end
      EE_ACK = 1'b0;
      chk("rec_end_busy", {31'd0, BUSY}, 0);
      chk("rec_end_gnt",  {30'd0, GNT1, GNT0}, 0);
      if (!keep) begin
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        step();
        chk("withdrawn_gnt",  {30'd0, GNT1, GNT0}, 0);
        chk("withdrawn_busy", {31'd0, BUSY}, 0);
      end
    end
  endtask

  initial begin
    logic [1:0]        mask;
    logic [DATA_W-1:0] rv;
    int                dly, sel;

    n_checks = 0;
    n_errors = 0;
    RESET = 1'b1;
    REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
    ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
    EE_ACK = 1'b0; tb_oe = 1'b0; tb_dat = '0;
    m_last = 1;
    m_rdata[0] = '0;
    m_rdata[1] = '0;

    step();
    step();
    chk_reset_vals("reset");
    RESET = 1'b0;
    step();

    // Port 0 write, ack 20 cycles after EE_WR
    WE0 = 1'b1; ADDR0 = 11'h123; WDATA0 = 8'hA5;
    txn(2'b01, 1'b0, 20, 8'h00, won);

    // Port 1 read of the top address returning 8'h3C
    WE1 = 1'b0; ADDR1 = 11'h7FF; WDATA1 = 8'h5A;
    txn(2'b10, 1'b0, 7, 8'h3C, won);
    chk("read_3c", {24'd0, RDATA1}, 32'h3C);

    // Port 0 read with no acknowledge: timeout, RDATA0 untouched
    WE0 = 1'b0; ADDR0 = 11'h055; WDATA0 = 8'h81;
    txn(2'b01, 1'b0, T + 1, 8'h00, won);

    // Ack on the very last timeout cycle: ack wins
    WE1 = 1'b0; ADDR1 = 11'h400; WDATA1 = 8'hC3;
    txn(2'b10, 1'b0, T, 8'h99, won);

    // Ack during the issue cycle is ignored; transaction times out
    WE0 = 1'b1; ADDR0 = 11'h001; WDATA0 = 8'h7E;
    txn(2'b01, 1'b0, 0, 8'h00, won);

    // Both ports requesting continuously: grants alternate
    WE0 = 1'b1; ADDR0 = 11'h010; WDATA0 = 8'h11;
    WE1 = 1'b0; ADDR1 = 11'h020; WDATA1 = 8'h22;
    prev_won = -1;
    for (int k = 0; k < 4; k++) begin
      txn(2'b11, 1'b1, $urandom_range(1, 10), 8'($urandom_range(0, 16)), won);
      if (k > 0) chk("rr_alternate", won, 1 - prev_won);
      prev_won = won;
    end
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    step();
    chk("rr_drop_gnt", {30'd0, GNT1, GNT0}, 0);

    // Reset in WAIT_ACK, then a stray ack
    WE0 = 1'b1; ADDR0 = 11'h2AA; WDATA0 = 8'h96;
    REQ0 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (GNT0) begin
        got = 1'b1;
        break;
      end
    end
    chk("rstmid_gnt", {31'd0, got}, 1);
    REQ0 = 1'b0;
    step();
    step();
    step();
    step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    m_last = 1;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    EE_ACK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_reset_vals("rstmid");
      chk("rstmid_ee_data_rel", {31'd0, (EE_DATA !== 8'h96)}, 1);
      step();
      EE_ACK = 1'b0;
    end
    WE0 = 1'b0; ADDR0 = 11'h3A0; WDATA0 = 8'h44;
    WE1 = 1'b1; ADDR1 = 11'h0F0; WDATA1 = 8'h55;
    txn(2'b11, 1'b0, 3, 8'hE7, won);
    chk("rstmid_rr_port0", won, 0);

    // Randomized transactions
    for (int n = 0; n < 16; n++) begin
      mask   = 2'($urandom_range(1, 3));
      WE0    = 1'($urandom);
      WE1    = 1'($urandom);
      ADDR0  = ADDR_W'($urandom);
      ADDR1  = ADDR_W'($urandom);
      WDATA0 = 8'($urandom_range(1, 255));
      WDATA1 = 8'($urandom_range(1, 255));
      rv     = 8'($urandom);
      while (rv == WDATA0 || rv == WDATA1) rv = rv + 8'd1;
      sel = $urandom_range(0, 9);
      if (sel == 0)      dly = 0;
      else if (sel == 1) dly = T;
      else if (sel == 2) dly = T + 1;
      else               dly = $urandom_range(1, T - 1);
      txn(mask, 1'b0, dly, rv, won);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
